issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 issue_valid  in  1  decode-stage bundle (upper+lower slot) presented for issue.
REQ-004 flush  in  1  branch taken; bundle in decode is squashed this cycle.
REQ-005 u_ra, u_rb, u_rs  in  5 each  upper-slot source register indices.
REQ-006 u_ra_use, u_rb_use, u_rs_use  in  1 each  upper-slot source actually read.
REQ-007 u_rt  in  5  upper-slot destination index; u_rt_we in 1: destination written.
REQ-008 u_lat  in  2  upper latency class: 0=ALU(1), 1=load(3), 2=FP pipe(4), 3=long div/sqrt(8).
REQ-009 l_ra, l_rb, l_rs, l_*_use, l_rt, l_rt_we, l_lat  in  same widths  lower-slot equivalents.
REQ-010 interlock  out  1  combinational; bundle must be held in decode.
REQ-011 pending_mask  out  32  bit i = GPR i has an unavailable result.
REQ-012 div_busy  out  1  long-latency unit occupied.
REQ-013 stall_count  out  32  interlocked-cycle counter.

Function
REQ-014 Each GPR SHALL have a 3-bit countdown counter cnt[i]; nonzero counters decrement by 1 every cycle.
REQ-015 Issue SHALL occur when issue_valid & ~interlock & ~flush; both slots issue together or neither.
REQ-016 On issue with rt_we=1, cnt[rt] SHALL load L-1 (L = 1, 3, 4, 8 per class); the load overrides that cycle's decrement.
REQ-017 If both slots write the same rt on issue, the larger L-1 SHALL be loaded.
REQ-018 RAW: interlock SHALL assert if any used source index has cnt != 0.
REQ-019 WAW: interlock SHALL assert if any written rt has cnt != 0.
REQ-020 Structural: interlock SHALL assert if either slot is class 3 while the 3-bit div counter is nonzero; on issue of a class-3 op, the div counter SHALL load 7.
REQ-021 l_lat==3 SHALL be treated as class 2 (the decoder never places long ops in the lower slot).
REQ-022 Intra-bundle lower-reads-upper dependencies SHALL NOT be checked (bundle legality is guaranteed by the compiler).
REQ-023 interlock SHALL be 0 when issue_valid=0; flush SHALL NOT alter interlock but blocks counter loads.
REQ-024 Consequence: a dependent instruction issues exactly L cycles after its producer; ALU results never stall.
REQ-025 pending_mask and div_busy SHALL be registered-state decodes (cnt!=0, div counter!=0).

Reset
REQ-026 On rstn=0 at a clock edge, all cnt[i], the div counter and stall_count SHALL clear to 0.
REQ-027 During reset, interlock, pending_mask and div_busy SHALL read 0; reset mid-countdown discards all pending state.

Configuration
REQ-028 With macro ISSUE_SCOREBOARD_STATS_EN defined, stall_count SHALL increment each cycle issue_valid & interlock & ~flush holds, saturating at 32'hFFFFFFFF.
REQ-029 Without ISSUE_SCOREBOARD_STATS_EN, stall_count SHALL be constant 0 and no counter logic synthesised.

Verification
REQ-030 Load r5 (u_lat=1) at cycle t; next bundle reads r5 via u_ra -> interlock=1 at t+1 and t+2, 0 at t+3; pending_mask[5]=1 at t+1..t+2.
REQ-031 Fdiv r3 (class 3) at t, then fdiv r4 at t+1 -> interlock=1 t+1..t+7, issue at t+8; div_busy=1 t+1..t+7.
REQ-032 Addi r7 then add reading r7 in next bundle -> interlock never asserts, pending_mask stays 0.
REQ-033 Fmul r9 (class 2) issued with flush=1 -> cnt[9] stays 0; a subsequent reader of r9 issues without stall.
REQ-034 Upper writes r2 class 1, lower writes r2 class 2 in the same bundle -> cnt[2]=3; a WAW write to r2 interlocks for 3 cycles.
REQ-035 Load r1 at t, rstn=0 at t+1 -> pending_mask=0 at t+2, reader of r1 issues at t+2; with STATS_EN, stall_count=0 after reset and increments by exactly 2 in REQ-030.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Dual-slot issue scoreboard: per-GPR result countdowns plus a long-latency divider
// occupancy counter. Optional stall statistics are enabled by ISSUE_SCOREBOARD_STATS_EN.
module issue_scoreboard (
    input  logic        clk,
    input  logic        rstn,
    input  logic        issue_valid,
    input  logic        flush,
    input  logic [4:0]  u_ra,
    input  logic [4:0]  u_rb,
    input  logic [4:0]  u_rs,
    input  logic        u_ra_use,
    input  logic        u_rb_use,
    input  logic        u_rs_use,
    input  logic [4:0]  u_rt,
    input  logic        u_rt_we,
    input  logic [1:0]  u_lat,
    input  logic [4:0]  l_ra,
    input  logic [4:0]  l_rb,
    input  logic [4:0]  l_rs,
    input  logic        l_ra_use,
    input  logic        l_rb_use,
    input  logic        l_rs_use,
    input  logic [4:0]  l_rt,
    input  logic        l_rt_we,
    input  logic [1:0]  l_lat,
    output logic        interlock,
    output logic [31:0] pending_mask,
    output logic        div_busy,
    output logic [31:0] stall_count
);

    localparam int NREG = 32;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_FP   = 2'd2;
    localparam logic [1:0] CLS_LONG = 2'd3;

    // Countdown value loaded on issue: latency minus one.
    function automatic logic [2:0] lat_load(input logic [1:0] cls);
        logic [2:0] v;
        case (cls)
            CLS_ALU:  v = 3'd0;
            CLS_LOAD: v = 3'd2;
            CLS_FP:   v = 3'd3;
            default:  v = 3'd7;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [2:0]      cnt     [NREG];
    logic [2:0]      cnt_nxt [NREG];
    logic [2:0]      div_cnt;
    logic [2:0]      div_cnt_nxt;
    logic [NREG-1:0] busy;

    logic [1:0]      l_cls;
    logic [2:0]      u_load;
    logic [2:0]      l_load;
    logic            raw_hz;
    logic            waw_hz;
    logic            struct_hz;
    logic            hazard;
    logic            do_issue;
    logic [NREG-1:0] u_hit;
    logic [NREG-1:0] l_hit;

    // The lower slot never carries long ops, so its class 3 folds into the FP pipe.
    assign l_cls  = (l_lat == CLS_LONG) ? CLS_FP : l_lat;
    assign u_load = lat_load(u_lat);
    assign l_load = lat_load(l_cls);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy[i] = (cnt[i] != 3'd0);
        end
    end

    // Lower-slot reads of the upper-slot destination are bundle-legal and not checked.
    assign raw_hz = (u_ra_use & busy[u_ra]) | (u_rb_use & busy[u_rb]) | (u_rs_use & busy[u_rs])
                  | (l_ra_use & busy[l_ra]) | (l_rb_use & busy[l_rb]) | (l_rs_use & busy[l_rs]);
    assign waw_hz    = (u_rt_we & busy[u_rt]) | (l_rt_we & busy[l_rt]);
    assign struct_hz = (u_lat == CLS_LONG) & (div_cnt != 3'd0);
    assign hazard    = raw_hz | waw_hz | struct_hz;

    assign interlock = rstn & issue_valid & hazard;
    assign do_issue  = rstn & issue_valid & ~hazard & ~flush;

    assign u_hit = (do_issue & u_rt_we) ? (NREG'(1) << u_rt) : '0;
    assign l_hit = (do_issue & l_rt_we) ? (NREG'(1) << l_rt) : '0;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt[i] = cnt[i];
            if (u_hit[i] && l_hit[i]) begin
                cnt_nxt[i] = max3(u_load, l_load);
            end else if (u_hit[i]) begin
                cnt_nxt[i] = u_load;
            end else if (l_hit[i]) begin
                cnt_nxt[i] = l_load;
            end else if (cnt[i] != 3'd0) begin
                cnt_nxt[i] = cnt[i] - 3'd1;
            end
        end
    end

    always_comb begin
        div_cnt_nxt = div_cnt;
        if (do_issue && (u_lat == CLS_LONG)) begin
            div_cnt_nxt = 3'd7;
        end else if (div_cnt != 3'd0) begin
            div_cnt_nxt = div_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= 3'd0;
            end
            div_cnt <= 3'd0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            div_cnt <= div_cnt_nxt;
        end
    end

    assign pending_mask = rstn ? busy : '0;
    assign div_busy     = rstn & (div_cnt != 3'd0);

`ifdef ISSUE_SCOREBOARD_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= 32'd0;
        end else if (issue_valid && interlock && !flush) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hazard timing, flush, bundle WAW merge,
// divider occupancy and mid-countdown reset.
module tb_issue_scoreboard;

    logic        clk;
    logic        rstn;
    logic        issue_valid;
    logic        flush;
    logic [4:0]  u_ra, u_rb, u_rs, u_rt;
    logic        u_ra_use, u_rb_use, u_rs_use, u_rt_we;
    logic [1:0]  u_lat;
    logic [4:0]  l_ra, l_rb, l_rs, l_rt;
    logic        l_ra_use, l_rb_use, l_rs_use, l_rt_we;
    logic [1:0]  l_lat;
    logic        interlock;
    logic [31:0] pending_mask;
    logic        div_busy;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_stall = 32'd0;

    issue_scoreboard dut (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .flush(flush),
        .u_ra(u_ra), .u_rb(u_rb), .u_rs(u_rs),
        .u_ra_use(u_ra_use), .u_rb_use(u_rb_use), .u_rs_use(u_rs_use),
        .u_rt(u_rt), .u_rt_we(u_rt_we), .u_lat(u_lat),
        .l_ra(l_ra), .l_rb(l_rb), .l_rs(l_rs),
        .l_ra_use(l_ra_use), .l_rb_use(l_rb_use), .l_rs_use(l_rs_use),
        .l_rt(l_rt), .l_rt_we(l_rt_we), .l_lat(l_lat),
        .interlock(interlock), .pending_mask(pending_mask),
        .div_busy(div_busy), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag);
`ifdef ISSUE_SCOREBOARD_STATS_EN
        chk(tag, stall_count, exp_stall);
`else
        chk(tag, stall_count, 32'd0);
`endif
    endtask

    task automatic idle();
        issue_valid = 0; flush = 0;
        u_ra = 0; u_rb = 0; u_rs = 0; u_rt = 0;
        u_ra_use = 0; u_rb_use = 0; u_rs_use = 0; u_rt_we = 0; u_lat = 0;
        l_ra = 0; l_rb = 0; l_rs = 0; l_rt = 0;
        l_ra_use = 0; l_rb_use = 0; l_rs_use = 0; l_rt_we = 0; l_lat = 0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rstn = 0;
        repeat (3) @(posedge clk);
        #1;
        // reset: outputs forced low even with a bundle presented
        issue_valid = 1; u_ra = 5'd3; u_ra_use = 1;
        mid();
        chk("rst_interlock", {31'd0, interlock}, 32'd0);
        chk("rst_pending", pending_mask, 32'd0);
        chk("rst_div_busy", {31'd0, div_busy}, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        tick();
        rstn = 1; idle();
        tick();

        // load r5 then dependent read
        idle(); issue_valid = 1; u_rt = 5'd5; u_rt_we = 1; u_lat = 2'd1;
        mid(); chk("ld_issue_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle(); issue_valid = 1; u_ra = 5'd5; u_ra_use = 1;
        mid(); chk("ld_t1_interlock", {31'd0, interlock}, 32'd1);
        chk("ld_t1_pending", pending_mask, 32'h0000_0020);
        tick();
        mid(); chk("ld_t2_interlock", {31'd0, interlock}, 32'd1);
        chk("ld_t2_pending", pending_mask, 32'h0000_0020);
        tick();
        exp_stall = exp_stall + 32'd2;
        mid(); chk("ld_t3_interlock", {31'd0, interlock}, 32'd0);
        chk("ld_t3_pending", pending_mask, 32'd0);
        chk_stall("ld_stall");
        tick();

        // ALU producer then consumer: never stalls
        idle(); issue_valid = 1; u_rt = 5'd7; u_rt_we = 1; u_lat = 2'd0;
        mid(); chk("alu_issue_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle(); issue_valid = 1; l_rb = 5'd7; l_rb_use = 1;
        mid(); chk("alu_dep_interlock", {31'd0, interlock}, 32'd0);
        chk("alu_dep_pending", pending_mask, 32'd0);
        tick();

        // back-to-back long divides
        idle(); issue_valid = 1; u_rt = 5'd3; u_rt_we = 1; u_lat = 2'd3;
        mid(); chk("div0_interlock", {31'd0, interlock}, 32'd0);
        chk("div0_busy", {31'd0, div_busy}, 32'd0);
        tick();
        idle(); issue_valid = 1; u_rt = 5'd4; u_rt_we = 1; u_lat = 2'd3;
        for (int k = 1; k <= 7; k++) begin
            mid();
            chk($sformatf("div1_t%0d_interlock", k), {31'd0, interlock}, 32'd1);
            chk($sformatf("div1_t%0d_busy", k), {31'd0, div_busy}, 32'd1);
            if (k == 1) chk("div1_t1_pending", pending_mask, 32'h0000_0008);
            tick();
        end
        exp_stall = exp_stall + 32'd7;
        mid(); chk("div1_t8_interlock", {31'd0, interlock}, 32'd0);
        chk("div1_t8_busy", {31'd0, div_busy}, 32'd0);
        chk("div1_t8_pending", pending_mask, 32'd0);
        chk_stall("div_stall");
        tick();
        // lower-slot class 3 behaves as FP pipe: no structural stall, 4-cycle latency
        idle(); issue_valid = 1; l_rt = 5'd6; l_rt_we = 1; l_lat = 2'd3;
        mid(); chk("lo_long_busy", {31'd0, div_busy}, 32'd1);
        chk("lo_long_pending", pending_mask, 32'h0000_0010);
        chk("lo_long_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle();
        mid(); chk("lo_long_t1_pending", pending_mask, 32'h0000_0050);
        tick(); tick();
        mid(); chk("lo_long_t3_pending", pending_mask, 32'h0000_0050);
        tick();
        mid(); chk("lo_long_t4_pending", pending_mask, 32'h0000_0010);
        repeat (5) tick();
        mid(); chk("drain_pending", pending_mask, 32'd0);
        chk("drain_busy", {31'd0, div_busy}, 32'd0);
        tick();

        // flushed producer leaves no pending state
        idle(); issue_valid = 1; flush = 1; u_rt = 5'd9; u_rt_we = 1; u_lat = 2'd2;
        mid(); chk("flush_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle(); issue_valid = 1; u_rs = 5'd9; u_rs_use = 1;
        mid(); chk("flush_dep_interlock", {31'd0, interlock}, 32'd0);
        chk("flush_dep_pending", pending_mask, 32'd0);
        tick();

        // both slots write r2: longer latency wins; flush does not mask interlock
        idle(); issue_valid = 1;
        u_rt = 5'd2; u_rt_we = 1; u_lat = 2'd1;
        l_rt = 5'd2; l_rt_we = 1; l_lat = 2'd2;
        mid(); chk("waw_issue_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle(); issue_valid = 1; u_rt = 5'd2; u_rt_we = 1; u_lat = 2'd0;
        mid(); chk("waw_t1_interlock", {31'd0, interlock}, 32'd1);
        chk("waw_t1_pending", pending_mask, 32'h0000_0004);
        tick();
        flush = 1;
        mid(); chk("waw_t2_flush_interlock", {31'd0, interlock}, 32'd1);
        tick();
        flush = 0;
        mid(); chk("waw_t3_interlock", {31'd0, interlock}, 32'd1);
        tick();
        exp_stall = exp_stall + 32'd2;
        mid(); chk("waw_t4_interlock", {31'd0, interlock}, 32'd0);
        chk_stall("waw_stall");
        tick();
        idle();
        mid(); chk("waw_alu_pending", pending_mask, 32'd0);
        tick();

        // intra-bundle dependency ignored; no interlock without issue_valid
        idle(); issue_valid = 1; u_rt = 5'd10; u_rt_we = 1; u_lat = 2'd1;
        l_ra = 5'd10; l_ra_use = 1;
        mid(); chk("intra_interlock", {31'd0, interlock}, 32'd0);
        tick();
        idle(); u_ra = 5'd10; u_ra_use = 1;
        mid(); chk("novalid_interlock", {31'd0, interlock}, 32'd0);
        chk("novalid_pending", pending_mask, 32'h0000_0400);
        tick();
        issue_valid = 1;
        mid(); chk("valid_interlock", {31'd0, interlock}, 32'd1);
        tick();
        exp_stall = exp_stall + 32'd1;
        mid(); chk("valid_t3_interlock", {31'd0, interlock}, 32'd0);
        chk_stall("valid_stall");
        tick();

        // reset mid-countdown discards pending state
        idle(); issue_valid = 1; u_rt = 5'd1; u_rt_we = 1; u_lat = 2'd1;
        tick();
        idle(); issue_valid = 1; u_ra = 5'd1; u_ra_use = 1;
        rstn = 0;
        mid(); chk("mrst_interlock", {31'd0, interlock}, 32'd0);
        chk("mrst_pending", pending_mask, 32'd0);
        tick();
        rstn = 1;
        exp_stall = 32'd0;
        mid(); chk("post_rst_interlock", {31'd0, interlock}, 32'd0);
        chk("post_rst_pending", pending_mask, 32'd0);
        chk("post_rst_stall", stall_count, 32'd0);
        tick();
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
